// File: rtl/window_shifter_if.sv
// window_shifter_if: slice input, window output and flush/error signals of the window shifter
interface window_shifter_if #(
  parameter int WIN = 3,
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
);
  logic flush;
  logic slice_valid;
  logic slice_ready;
  logic [1:0] slice_dir;
  logic [WIN*PIX_W-1:0] slice_data;
  logic win_valid;
  logic win_ready;
  logic [WIN*WIN*PIX_W-1:0] win_data;
  logic [$clog2(IMG_W)-1:0] win_x;
  logic [$clog2(IMG_H)-1:0] win_y;
  logic err;
  modport master (
    output flush, slice_valid, slice_dir, slice_data, win_ready,
    input slice_ready, win_valid, win_data, win_x, win_y, err
  );
  modport slave (
    input flush, slice_valid, slice_dir, slice_data, win_ready,
    output slice_ready, win_valid, win_data, win_x, win_y, err
  );
endinterface

// File: rtl/window_shifter.sv
// window_shifter: WIN x WIN pixel window built and slid one row/column slice at a time
module window_shifter #(
  parameter int WIN = 3,
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input logic clk,
  input logic rst,
  window_shifter_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int DW = WIN*WIN*PIX_W;
  typedef enum logic [1:0] {EMPTY, FILL, HOLD, WAIT} state_t;
  state_t state;
  logic [3:0] fill_cnt, next_cnt;
  logic [DW-1:0] win, up, left, right, moved;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic err, accept, done, move_ok;
  assign bus.slice_ready = !rst && !bus.flush && state != HOLD;
  assign accept = bus.slice_valid && bus.slice_ready;
  assign bus.win_valid = state == HOLD;
  assign bus.win_data = win;
  assign bus.win_x = x;
  assign bus.win_y = y;
  assign bus.err = err;
  // a fill from WAIT restarts the row count at one; otherwise it keeps counting
  assign next_cnt = state == WAIT ? 4'd1 : fill_cnt + 4'd1;
  assign done = int'(next_cnt) == WIN;
  assign move_ok = bus.slice_dir == 2'b00 ? int'(x) + WIN < IMG_W :
                   bus.slice_dir == 2'b01 ? x != '0 : int'(y) + WIN < IMG_H;
  assign moved = bus.slice_dir == 2'b00 ? left : bus.slice_dir == 2'b01 ? right : up;
  // candidate windows: rows up with slice as bottom row, columns left/right with slice as the new edge column
  always_comb begin
    up = '0;
    left = '0;
    right = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        up[(r*WIN+c)*PIX_W +: PIX_W] = r == WIN-1 ? bus.slice_data[c*PIX_W +: PIX_W]
                                                  : win[(((r+1)%WIN)*WIN+c)*PIX_W +: PIX_W];
        left[(r*WIN+c)*PIX_W +: PIX_W] = c == WIN-1 ? bus.slice_data[r*PIX_W +: PIX_W]
                                                    : win[(r*WIN+(c+1)%WIN)*PIX_W +: PIX_W];
        right[(r*WIN+c)*PIX_W +: PIX_W] = c == 0 ? bus.slice_data[r*PIX_W +: PIX_W]
                                                 : win[(r*WIN+(c+WIN-1)%WIN)*PIX_W +: PIX_W];
      end
    end
  end
  // control FSM, window register, coordinates and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      fill_cnt <= '0;
      win <= '0;
      x <= '0;
      y <= '0;
      err <= 1'b0;
    end else if (bus.flush) begin
      state <= EMPTY;
      fill_cnt <= '0;
      win <= '0;
      x <= '0;
      y <= '0;
    end else if (state == HOLD) begin
      if (bus.win_ready) state <= WAIT;
    end else if (accept) begin
      if (bus.slice_dir == 2'b11) begin
        win <= up;
        fill_cnt <= next_cnt;
        state <= done ? HOLD : FILL;
        if (done) begin
          x <= '0;
          y <= '0;
        end
      end else if (state != WAIT) begin
        err <= 1'b1;
      end else begin
        state <= HOLD;
        if (move_ok) begin
          win <= moved;
          x <= bus.slice_dir == 2'b00 ? x + 1'b1 : bus.slice_dir == 2'b01 ? x - 1'b1 : x;
          y <= bus.slice_dir == 2'b10 ? y + 1'b1 : y;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_window_shifter.sv
// tb_window_shifter: scoreboard bench with a pixel-array reference model of the window shifter
module tb_window_shifter;
  localparam int WIN = 3, PIX_W = 8, IMG_W = 8, IMG_H = 6;
  localparam int SW = WIN*PIX_W, DW = WIN*WIN*PIX_W;
  localparam int M_EMPTY = 0, M_FILL = 1, M_HOLD = 2, M_WAIT = 3;
  typedef struct {
    logic [DW-1:0] d;
    int x;
    int y;
    logic e;
  } exp_t;
  logic clk, rst;
  int checks, failures;
  exp_t q[$];
  exp_t cur;
  logic [PIX_W-1:0] m [WIN][WIN];
  int mst, mcnt, mx, my;
  logic merr;
  window_shifter_if #(.WIN(WIN), .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) w();
  window_shifter #(.WIN(WIN), .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .bus(w.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] flat();
    logic [DW-1:0] f;
    f = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) f[(r*WIN+c)*PIX_W +: PIX_W] = m[r][c];
    return f;
  endfunction
  task automatic model_clear(input logic clr_err);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) m[r][c] = '0;
    mst = M_EMPTY; mcnt = 0; mx = 0; my = 0;
    if (clr_err) merr = 1'b0;
  endtask
  task automatic push_exp();
    exp_t e;
    e.d = flat(); e.x = mx; e.y = my; e.e = merr;
    q.push_back(e);
  endtask
  task automatic model_slice(input logic [1:0] d, input logic [SW-1:0] s);
    if (d == 2'b11) begin
      for (int r = 0; r < WIN-1; r++) m[r] = m[r+1];
      for (int c = 0; c < WIN; c++) m[WIN-1][c] = s[c*PIX_W +: PIX_W];
      mcnt = (mst == M_WAIT) ? 1 : mcnt + 1;
      if (mcnt == WIN) begin
        mst = M_HOLD; mx = 0; my = 0;
        push_exp();
      end else mst = M_FILL;
    end else if (mst != M_WAIT) begin
      merr = 1'b1;
    end else begin
      mst = M_HOLD;
      if (d == 2'b00 && mx + WIN < IMG_W) begin
        for (int r = 0; r < WIN; r++) begin
          for (int c = 0; c < WIN-1; c++) m[r][c] = m[r][c+1];
          m[r][WIN-1] = s[r*PIX_W +: PIX_W];
        end
        mx++;
      end else if (d == 2'b01 && mx > 0) begin
        for (int r = 0; r < WIN; r++) begin
          for (int c = WIN-1; c > 0; c--) m[r][c] = m[r][c-1];
          m[r][0] = s[r*PIX_W +: PIX_W];
        end
        mx--;
      end else if (d == 2'b10 && my + WIN < IMG_H) begin
        for (int r = 0; r < WIN-1; r++) m[r] = m[r+1];
        for (int c = 0; c < WIN; c++) m[WIN-1][c] = s[c*PIX_W +: PIX_W];
        my++;
      end else merr = 1'b1;
      push_exp();
    end
  endtask
  task automatic ack();
    int n;
    @(negedge clk);
    n = 0;
    while (!w.win_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!w.win_valid) chk("ack_timeout", 0, 1);
    w.win_ready = 1'b1;
    @(negedge clk);
    w.win_ready = 1'b0;
    mst = M_WAIT;
  endtask
  task automatic send(input logic [1:0] d, input logic [SW-1:0] s);
    int n;
    if (mst == M_HOLD) ack();
    @(negedge clk);
    w.slice_valid = 1'b1; w.slice_dir = d; w.slice_data = s;
    n = 0;
    while (!w.slice_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!w.slice_ready) chk("send_timeout", 0, 1);
    else begin
      @(posedge clk);
      model_slice(d, s);
    end
    #1 w.slice_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", w.slice_ready, 0);
    chk("rst_valid", w.win_valid, 0);
    chk("rst_data", w.win_data, 0);
    chk("rst_x", w.win_x, 0);
    chk("rst_y", w.win_y, 0);
    chk("rst_err", w.err, 0);
    model_clear(1'b1);
    q.delete();
    rst = 1'b0;
  endtask
  task automatic do_flush();
    @(negedge clk);
    w.flush = 1'b1;
    @(posedge clk);
    model_clear(1'b0);
    #1 w.flush = 1'b0;
  endtask
  // monitor: a rising win_valid pops the next expected window; every valid cycle is compared
  logic prev;
  initial prev = 1'b0;
  always @(negedge clk) begin
    if (rst) prev = 1'b0;
    else begin
      if (w.win_valid) begin
        if (!prev) begin
          if (q.size() == 0) chk("unexpected_window", 1, 0);
          else cur = q.pop_front();
        end
        chk("win_data", w.win_data, cur.d);
        chk("win_x", w.win_x, cur.x);
        chk("win_y", w.win_y, cur.y);
        chk("win_err", w.err, cur.e);
      end
      prev = w.win_valid;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    w.flush = 1'b0; w.slice_valid = 1'b0; w.slice_dir = 2'b00; w.slice_data = '0; w.win_ready = 1'b0;
    model_clear(1'b1);
    repeat (2) @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("ready_after_rst", w.slice_ready, 1);
    send(2'b11, 24'h030201);
    send(2'b11, 24'h060504);
    send(2'b11, 24'h090807);
    @(negedge clk);
    chk("fill_valid", w.win_valid, 1);
    chk("fill_row0", w.win_data[23:0], 24'h030201);
    send(2'b00, 24'h0C0B0A);
    @(negedge clk);
    chk("right_row0", w.win_data[23:0], 24'h0A0302);
    chk("right_row2", w.win_data[71:48], 24'h0C0908);
    chk("right_x", w.win_x, 1);
    repeat (4) send(2'b00, SW'($urandom));
    @(negedge clk);
    chk("five_rights_x", w.win_x, 5);
    chk("no_err_yet", w.err, 0);
    send(2'b00, SW'($urandom));
    @(negedge clk);
    chk("sixth_right_err", w.err, 1);
    chk("sixth_right_x", w.win_x, 5);
    chk("sixth_right_valid", w.win_valid, 1);
    repeat (5) send(2'b01, SW'($urandom));
    send(2'b01, SW'($urandom));
    @(negedge clk);
    chk("left_at_zero_x", w.win_x, 0);
    send(2'b10, 24'hCCBBAA);
    @(negedge clk);
    chk("down_row2", w.win_data[71:48], 24'hCCBBAA);
    chk("down_y", w.win_y, 1);
    w.slice_valid = 1'b1; w.slice_dir = 2'b10; w.slice_data = 24'h332211;
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", w.slice_ready, 0);
    end
    w.win_ready = 1'b1;
    @(negedge clk);
    w.win_ready = 1'b0;
    mst = M_WAIT;
    chk("wait_ready", w.slice_ready, 1);
    @(posedge clk);
    model_slice(2'b10, 24'h332211);
    #1 w.slice_valid = 1'b0;
    ack();
    @(negedge clk);
    w.flush = 1'b1; w.slice_valid = 1'b1; w.slice_dir = 2'b11; w.slice_data = 24'h777777;
    #1 chk("flush_ready", w.slice_ready, 0);
    @(posedge clk);
    model_clear(1'b0);
    #1 w.flush = 1'b0; w.slice_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", w.win_valid, 0);
    chk("flush_data", w.win_data, 0);
    chk("flush_y", w.win_y, 0);
    chk("flush_err_kept", w.err, merr);
    send(2'b11, 24'h111111);
    send(2'b11, 24'h222222);
    do_reset();
    send(2'b11, 24'h453423);
    send(2'b11, 24'h786756);
    send(2'b11, 24'hAB9A89);
    @(negedge clk);
    chk("refill_valid", w.win_valid, 1);
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (mst == M_HOLD) ack();
      else if (r == 0) do_flush();
      else if (r <= 4) send(2'b11, SW'($urandom));
      else send(2'($urandom_range(0, 2)), SW'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/window_shifter.md
WINDOW_SHIFTER -- requirements
Module: window_shifter

Interface
REQ-001 Parameter WIN, default 3: window edge in pixels, legal range 2..15.
REQ-002 Parameter PIX_W, default 8: pixel width in bits.
REQ-003 Parameter IMG_W, default 64: image width in pixels, must be at least WIN.
REQ-004 Parameter IMG_H, default 48: image height in pixels, must be at least WIN.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous clear of the window; returns the block to EMPTY.
REQ-008 slice_valid  in  1  slice_data/slice_dir present.
REQ-009 slice_ready  out  1  block accepts a slice this cycle.
REQ-010 slice_dir  in  2  00 = shift right, 01 = shift left, 10 = shift down, 11 = fill row.
REQ-011 slice_data  in  WIN*PIX_W  new column or row; element i at [i*PIX_W +: PIX_W].
REQ-012 win_valid  out  1  window complete and stable.
REQ-013 win_ready  in  1  consumer (kernel) done with the current window.
REQ-014 win_data  out  WIN*WIN*PIX_W  pixel (r,c) at [(r*WIN+c)*PIX_W +: PIX_W]; r = row, c = column.
REQ-015 win_x  out  $clog2(IMG_W)  image column of window pixel (0,0).
REQ-016 win_y  out  $clog2(IMG_H)  image row of window pixel (0,0).
REQ-017 err  out  1  sticky illegal-command flag.

Function
REQ-018 A slice is accepted when slice_valid & slice_ready are high at a rising edge; slice_ready shall not depend on slice_valid.
REQ-019 States: EMPTY, FILL, HOLD, WAIT; slice_ready=1 in EMPTY/FILL/WAIT and 0 in HOLD; slice_ready=0 whenever rst or flush is high.
REQ-020 Fill (dir 11) accepted: rows move up one (row r takes row r+1), slice_data becomes row WIN-1 (element i to column i), fill_cnt increments.
REQ-021 EMPTY + fill: fill_cnt=1, go to FILL; FILL + fill: when fill_cnt reaches WIN, go to HOLD with win_x=0, win_y=0.
REQ-022 Dir 00/01/10 accepted in EMPTY or FILL: slice discarded, err set, state unchanged.
REQ-023 HOLD: win_valid=1; on win_valid & win_ready go to WAIT, win_valid=0 next cycle.
REQ-024 WAIT + dir 00, when win_x+WIN<IMG_W: columns move left (col c takes col c+1), slice element i becomes (i,WIN-1), win_x++, go to HOLD.
REQ-025 WAIT + dir 01, when win_x>0: columns move right, slice element i becomes (i,0), win_x--, go to HOLD.
REQ-026 WAIT + dir 10, when win_y+WIN<IMG_H: rows move up, slice element i becomes (WIN-1,i), win_y++, go to HOLD; win_x unchanged.
REQ-027 WAIT + out-of-range shift: slice consumed, window and coordinates unchanged, err set, go to HOLD.
REQ-028 WAIT + fill: restart; fill_cnt=1, the slice loads row WIN-1, go to FILL; win_x/win_y reset to 0 when the fill completes.
REQ-029 Latency: a slice accepted at edge N that completes a window makes win_valid=1 and updates win_data/win_x/win_y in the cycle after edge N.
REQ-030 win_data, win_x and win_y hold stable while win_valid=1.
REQ-031 flush high at an edge: state EMPTY, fill_cnt=0, win_valid=0, win_data=0, win_x=win_y=0, err unchanged; a concurrent slice is not accepted.

Reset
REQ-032 rst high at an edge: state EMPTY, fill_cnt=0, win_valid=0, win_data=0, win_x=0, win_y=0, err=0.
REQ-033 rst takes priority over flush and over any handshake; rst mid-fill or mid-HOLD discards the partial window.

Verification
REQ-034 WIN=3, PIX_W=8, IMG_W=8, IMG_H=6; three fill slices {01,02,03},{04,05,06},{07,08,09} -> win_valid=1 one cycle after the third, row0={01,02,03}, win_x=0, win_y=0.
REQ-035 After REQ-034, pulse win_ready, then dir 00 slice {0A,0B,0C} -> row0={02,03,0A}, row2={08,09,0C}, win_x=1.
REQ-036 Five rights from win_x=0 reach win_x=5; a sixth right -> err=1, window unchanged, win_valid re-asserts.
REQ-037 Dir 01 at win_x=0 -> err=1; dir 10 slice {AA,BB,CC} at win_y=0 -> row2={AA,BB,CC}, win_y=1.
REQ-038 slice_valid held high during HOLD -> no acceptance until win_ready; flush concurrent with slice_valid -> EMPTY, slice dropped.
REQ-039 rst after two fill slices -> all outputs zero; a fresh three-slice fill produces a correct window.
